bram_stream_reader: RTL and testbench

Read-side streaming controller for the single-port, one-cycle-latency BRAM used across GACT. On a start command it walks a contiguous address range, ascending or descending, and delivers the words on a valid/ready stream with full backpressure and one word per cycle sustained throughput. The block only reads the BRAM: it drives the address and consumes the registered read data. Write access and port muxing are owned by the surrounding logic.

---
 rtl/bram_stream_reader.sv | 121 ++++++++++++
 tb/tb_bram_stream_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM address range (up/down, wrapping) onto a valid/ready port.
// First word 3 cycles after start; one word/cycle sustained; 4-entry FIFO credits stop reads under backpressure.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  descend,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH:0]   ONE_R = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  logic [1:0]            state;
  logic                  dir_down;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  rd_vld;
  logic                  rd_last;
  logic [DATA_WIDTH:0]   fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;
  logic [3:0]            credit_used;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  drain_done;

  // A read in the data stage already owns a FIFO slot, so it counts against credit.
  assign credit_used = {1'b0, fifo_count} + {3'b000, rd_vld};
  assign issue       = (state == READ) && (remaining != '0) && (credit_used < 4'd4);
  assign push        = rd_vld;
  assign pop         = out_valid && out_ready;

  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid ? fifo_mem[rd_ptr][DATA_WIDTH] : 1'b0;

  assign drain_done = (state == DRAIN) && !rd_vld &&
                      ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && pop));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {rd_last, bram_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir_down   <= 1'b0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_addr  <= '0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      done    <= 1'b0;
      rd_vld  <= issue;
      rd_last <= issue && (remaining == ONE_R);

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      fifo_count <= fifo_count + 3'd1;
      else if (!push && pop) fifo_count <= fifo_count - 3'd1;

      case (state)
        IDLE: begin
          if (start) begin
            dir_down  <= descend;
            bram_addr <= start_addr;
            remaining <= length;
            // An empty command has nothing to drain, so it completes straight away.
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            remaining <= remaining - ONE_R;
            bram_addr <= dir_down ? bram_addr - ONE_A : bram_addr + ONE_A;
            if (remaining == ONE_R) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: table of commands, corner sequences, random commands vs a queue model.
module tb_bram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       descend;
  logic       busy;
  logic       done;
  logic [3:0] bram_addr;
  logic [7:0] bram_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  logic [7:0] mem [16];
  int errors = 0;
  int checks = 0;
  logic [7:0] got_first;
  logic [7:0] got_last;

  always #5 clk = ~clk;

  always @(posedge clk) bram_data <= mem[bram_addr];

  bram_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .descend(descend), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_data(bram_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  typedef struct packed {
    logic [3:0] sa;
    logic [4:0] len;
    logic       desc;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
  endtask

  // Runs one command to completion and scores the stream against the address walk.
  task automatic run_cmd(input logic [3:0] sa, input logic [4:0] len, input logic desc,
                         input bit rand_ready, input bit inject);
    logic [7:0] exp_q[$];
    logic [3:0] a;
    logic [3:0] prev_addr;
    logic [7:0] hdata;
    logic       hlast;
    bit         hold;
    bit         timed;
    int         cyc;
    int         issued;
    int         xfers;
    int         dones;

    timed = !rand_ready && !inject;
    a = sa;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(mem[a]);
      a = desc ? a - 4'd1 : a + 4'd1;
    end

    start = 1'b1; start_addr = sa; length = len; descend = desc; out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; issued = 0; xfers = 0; dones = 0; hold = 0;
    prev_addr = bram_addr;

    while (cyc < 400) begin
      if (hold) check("hold_stable", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, hlast, hdata});
      hold = 0;
      if (bram_addr !== prev_addr) issued++;
      prev_addr = bram_addr;
      check("occupancy_le4", 32'((issued - xfers) <= 4), 32'd1);
      if (done === 1'b1) begin
        dones++;
        check("done_after_last", exp_q.size(), 0);
        check("issued_total", issued, int'(len));
        check("busy_at_done", busy, 0);
        if (timed) check("done_cycle", cyc, int'(len) + 3);
        break;
      end
      if (timed) check("busy_window", busy, 32'(cyc <= int'(len) + 2));
      start = 1'b0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_word: got %0h expected no word", out_data);
          end else begin
            check("data", out_data, exp_q[0]);
            check("last", out_last, 32'(exp_q.size() == 1));
            if (xfers == 0) begin
              got_first = out_data;
              if (timed) check("first_cycle", cyc, 3);
            end
            if (exp_q.size() == 1) begin
              got_last = out_data;
              if (timed) check("last_cycle", cyc, int'(len) + 2);
            end
            void'(exp_q.pop_front());
            xfers++;
          end
        end else begin
          hold = 1; hdata = out_data; hlast = out_last;
        end
      end
      if (inject && cyc == 4) begin
        start = 1'b1; start_addr = 4'd9; length = 5'd2; descend = ~desc;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (dones == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_second_done", done, 0);
      check("idle_valid", out_valid, 0);
    end
  endtask

  initial begin
    preload();
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; descend = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", bram_addr, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{sa: 4'd2,  len: 5'd5,  desc: 1'b0, first: 8'h12, last: 8'h16};
    vecs[1] = '{sa: 4'd1,  len: 5'd4,  desc: 1'b1, first: 8'h11, last: 8'h1E};
    vecs[2] = '{sa: 4'd14, len: 5'd4,  desc: 1'b0, first: 8'h1E, last: 8'h11};
    vecs[3] = '{sa: 4'd0,  len: 5'd16, desc: 1'b0, first: 8'h10, last: 8'h1F};
    vecs[4] = '{sa: 4'd15, len: 5'd3,  desc: 1'b1, first: 8'h1F, last: 8'h1D};
    for (int v = 0; v < 5; v++) begin
      run_cmd(vecs[v].sa, vecs[v].len, vecs[v].desc, 1'b0, 1'b0);
      check("tbl_first", got_first, vecs[v].first);
      check("tbl_last", got_last, vecs[v].last);
    end

    // Zero-length command.
    start = 1'b1; start_addr = 4'd7; length = 5'd0; descend = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_valid", out_valid, 0);
    tick();
    check("len0_done_once", done, 0);
    check("len0_valid2", out_valid, 0);
    check("len0_busy", busy, 0);

    // Start while busy must be ignored.
    run_cmd(4'd4, 5'd16, 1'b0, 1'b0, 1'b1);
    check("inject_first", got_first, 8'h14);
    check("inject_last", got_last, 8'h13);

    // Full memory under random backpressure.
    run_cmd(4'd0, 5'd16, 1'b1, 1'b1, 1'b0);
    check("full_rand_first", got_first, 8'h10);
    check("full_rand_last", got_last, 8'h11);

    // Reset with three words buffered and the sink stalled.
    out_ready = 1'b0;
    start = 1'b1; start_addr = 4'd3; length = 5'd16; descend = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, 8'h13);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", bram_addr, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("post_rst_done", done, 0);
    check("post_rst_valid", out_valid, 0);
    run_cmd(4'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    check("post_rst_first", got_first, 8'h15);
    check("post_rst_last", got_last, 8'h10);

    // Random commands over random memory contents.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_cmd(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)),
              1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
